// File: rtl/instr_stream_sequencer_pkg.sv
// Shared types and default constants for the instruction stream sequencer.
package instr_stream_sequencer_pkg;

    localparam int unsigned DATA_W               = 10;
    localparam int unsigned DEFAULT_DEPTH        = 16;
    localparam int unsigned DEFAULT_PULSE_CYCLES = 4;
    localparam int unsigned DEFAULT_GAP_CYCLES   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE_HI = 2'd1,
        PULSE_LO = 2'd2
    } seq_state_t;

endpackage

// File: rtl/instr_stream_sequencer_fifo.sv
// Circular word buffer feeding the processor switch input; head word is exposed combinationally.
module seq_fifo10
    import instr_stream_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     not_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end

    assign count    = count_q;
    assign not_full = (count_q < CW'(DEPTH));
    assign head     = (count_q != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_stream_sequencer.sv
// Steps a processor through buffered switch words by generating Step_Clock pulses.
module instr_stream_sequencer
    import instr_stream_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned PULSE_CYCLES = DEFAULT_PULSE_CYCLES,
    parameter int unsigned GAP_CYCLES   = DEFAULT_GAP_CYCLES
) (
    input  logic                     Clock_50MHz,
    input  logic                     Reset_n,
    input  logic [DATA_W-1:0]        Wr_Data,
    input  logic                     Wr_Valid,
    output logic                     Wr_Ready,
    input  logic                     Start,
    input  logic                     Abort,
    input  logic                     Ext_Consume,
    input  logic                     Proc_Done,
    output logic [DATA_W-1:0]        Data_To_Switches,
    output logic                     Step_Clock,
    output logic                     Busy,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Underrun
);

    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam int unsigned TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX) + 1;

    seq_state_t    state, state_next;
    logic [TW-1:0] tmr, tmr_next;
    logic          consume_flag, empty_flag;
    logic          pop, push, underrun_set, not_full;
    logic [CW-1:0] count;

    // A full buffer still takes a word when the head leaves on the same edge.
    assign push = Wr_Valid && (not_full || pop) && !Abort;

    seq_fifo10 #(.DEPTH(DEPTH)) u_fifo (
        .clk      (Clock_50MHz),
        .rst_n    (Reset_n),
        .flush    (Abort),
        .push     (push),
        .pop      (pop),
        .wr_data  (Wr_Data),
        .head     (Data_To_Switches),
        .count    (count),
        .not_full (not_full)
    );

    always_ff @(posedge Clock_50MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            tmr          <= '0;
            consume_flag <= 1'b0;
            empty_flag   <= 1'b0;
            Underrun     <= 1'b0;
        end else begin
            state <= state_next;
            tmr   <= tmr_next;
            if (state == PULSE_HI && tmr == '0) begin
                consume_flag <= Ext_Consume;
                empty_flag   <= (count == '0);
            end
            if (Abort)             Underrun <= 1'b0;
            else if (underrun_set) Underrun <= 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        tmr_next     = tmr;
        pop          = 1'b0;
        underrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (Start && count != '0) begin
                    state_next = PULSE_HI;
                    tmr_next   = '0;
                end
            end
            PULSE_HI: begin
                if (tmr == TW'(PULSE_CYCLES - 1)) begin
                    state_next = PULSE_LO;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr + 1'b1;
                end
            end
            PULSE_LO: begin
                if (tmr == TW'(GAP_CYCLES - 1)) begin
                    tmr_next = '0;
                    if (consume_flag && empty_flag) begin
                        underrun_set = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        pop = consume_flag && (count != '0);
                        if (Proc_Done && (count - CW'(pop)) == '0) state_next = IDLE;
                        else                                       state_next = PULSE_HI;
                    end
                end else begin
                    tmr_next = tmr + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (Abort) begin
            state_next   = IDLE;
            tmr_next     = '0;
            pop          = 1'b0;
            underrun_set = 1'b0;
        end
    end

    assign Wr_Ready   = not_full;
    assign Step_Clock = (state == PULSE_HI);
    assign Busy       = (state != IDLE);
    assign Count      = count;

endmodule

// File: tb/tb_instr_stream_sequencer.sv
// Randomized and directed bench for instr_stream_sequencer against a queue/phase reference model.
module tb_instr_stream_sequencer;

    localparam int D = 16;
    localparam int P = 4;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ext_consume = 1'b0;
    logic       proc_done = 1'b0;
    logic [9:0] data_sw;
    logic       step_clk;
    logic       busy;
    logic [4:0] count;
    logic       underrun;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: buffered words plus position within the pulse period
    logic [9:0] q[$];
    bit         running;
    int         phase;
    bit         m_underrun;
    bit         cflag, eflag;

    instr_stream_sequencer #(
        .DEPTH(D), .PULSE_CYCLES(P), .GAP_CYCLES(G)
    ) dut (
        .Clock_50MHz      (clk),
        .Reset_n          (rst_n),
        .Wr_Data          (wr_data),
        .Wr_Valid         (wr_valid),
        .Wr_Ready         (wr_ready),
        .Start            (start),
        .Abort            (abort),
        .Ext_Consume      (ext_consume),
        .Proc_Done        (proc_done),
        .Data_To_Switches (data_sw),
        .Step_Clock       (step_clk),
        .Busy             (busy),
        .Count            (count),
        .Underrun         (underrun)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        running    = 0;
        phase      = 0;
        m_underrun = 0;
        cflag      = 0;
        eflag      = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit pop, stop, go;
        int sz;
        pop = 0; stop = 0; go = 0;
        sz = q.size();
        if (abort) begin
            model_reset();
            return;
        end
        if (running) begin
            if (phase == 0) begin
                cflag = ext_consume;
                eflag = (sz == 0);
            end
            if (phase == P + G - 1) begin
                if (cflag && eflag) begin
                    m_underrun = 1;
                    stop = 1;
                end else begin
                    pop = cflag && (sz > 0);
                    if (proc_done && (sz - int'(pop)) == 0) stop = 1;
                end
            end
        end else if (start && sz > 0) begin
            go = 1;
        end
        if (pop) void'(q.pop_front());
        if (wr_valid && (sz < D || pop)) q.push_back(wr_data);
        if (go) begin
            running = 1;
            phase   = 0;
        end else if (running) begin
            if (stop) begin
                running = 0;
                phase   = 0;
            end else begin
                phase = (phase == P + G - 1) ? 0 : phase + 1;
            end
        end
    endtask

    task automatic compare_all();
        check("step_clk", 32'(step_clk), 32'(running && phase < P));
        check("busy",     32'(busy),     32'(running));
        check("count",    32'(count),    32'(q.size()));
        check("wr_ready", 32'(wr_ready), 32'(q.size() < D));
        check("data_sw",  32'(data_sw),  (q.size() > 0) ? 32'(q[0]) : 32'h0);
        check("underrun", 32'(underrun), 32'(m_underrun));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        wr_valid = 0; start = 0; abort = 0; ext_consume = 0; proc_done = 0;
    endtask

    task automatic push_word(input logic [9:0] w);
        wr_valid = 1; wr_data = w;
        tick();
        wr_valid = 0;
    endtask

    task automatic do_abort();
        idle_inputs();
        abort = 1;
        tick();
        abort = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1;

        // three-word program, every pulse consumes
        push_word(10'h00F);
        push_word(10'h155);
        push_word(10'h2AA);
        check("d36_head", 32'(data_sw), 32'h00F);
        check("d36_count", 32'(count), 32'd3);
        start = 1; ext_consume = 1; proc_done = 1;
        tick();
        start = 0;
        repeat (30) tick();
        check("d36_count_end", 32'(count), 32'd0);
        check("d36_busy_end", 32'(busy), 32'd0);
        idle_inputs();

        // fill to capacity with a seventeenth offer
        do_abort();
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1; wr_data = 10'(i + 10'h100);
            tick();
        end
        wr_valid = 0;
        check("d37_count", 32'(count), 32'd16);
        check("d37_ready", 32'(wr_ready), 32'd0);

        // full buffer with continuous push while consuming
        start = 1; ext_consume = 1; proc_done = 0;
        tick();
        start = 0;
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1; wr_data = 10'($urandom);
            tick();
        end
        check("d39_count", 32'(count), 32'd16);
        idle_inputs();

        // pulse timing with one word, no consume
        do_abort();
        push_word(10'h3C3);
        start = 1;
        tick();
        start = 0;
        repeat (20) tick();
        check("d38_busy", 32'(busy), 32'd1);

        // underrun on an empty buffer
        do_abort();
        push_word(10'h001);
        start = 1; ext_consume = 1;
        tick();
        start = 0;
        repeat (2 * (P + G) + 2) tick();
        check("d40_underrun", 32'(underrun), 32'd1);
        check("d40_busy", 32'(busy), 32'd0);
        do_abort();
        check("d40_cleared", 32'(underrun), 32'd0);

        // asynchronous reset mid-pulse
        push_word(10'h0AA);
        push_word(10'h055);
        start = 1;
        tick();
        start = 0;
        tick();
        check("d41_pre_step", 32'(step_clk), 32'd1);
        rst_n = 0;
        #1;
        check("d41_rst_step", 32'(step_clk), 32'd0);
        check("d41_rst_count", 32'(count), 32'd0);
        check("d41_rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        compare_all();

        // abort mid-run
        push_word(10'h111);
        push_word(10'h222);
        start = 1;
        tick();
        start = 0;
        repeat (3) tick();
        do_abort();
        check("d41_abort_step", 32'(step_clk), 32'd0);
        check("d41_abort_count", 32'(count), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            wr_valid    = ($urandom_range(0, 1) == 1);
            wr_data     = 10'($urandom);
            start       = ($urandom_range(0, 9) == 0);
            abort       = ($urandom_range(0, 99) < 2);
            ext_consume = ($urandom_range(0, 1) == 1);
            proc_done   = ($urandom_range(0, 4) == 0);
            tick();
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
